// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-op combinational ALU: valid/ready instruction in, registered ALU drive,
// writeback to a small register file, valid/ready result out. Optional macro: STATUS_FLAGS_EN.
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd
`ifdef STATUS_FLAGS_EN
  ,
  output logic              res_zero,
  output logic              res_neg
`endif
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [REG_AW-1:0]   rs1_q, rs1_d;
  logic [REG_AW-1:0]   rs2_q, rs2_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [DATA_W-1:0]   rf_d [NREG];
  logic [2:0]          alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [REG_AW-1:0]   res_rd_q, res_rd_d;
  logic                res_zero_q, res_zero_d;
  logic                res_neg_q, res_neg_d;
  logic                unary_op;

  // inc/dec/inv only use A, so B is presented as zero for them
  assign unary_op = (op_q == 3'd2) || (op_q == 3'd3) || (op_q == 3'd4);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rf_d         = rf_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_rd_d     = res_rd_q;
    res_zero_d   = res_zero_q;
    res_neg_d    = res_neg_q;
    case (state_q)
      S_IDLE: begin
        if (ld_en) begin
          rf_d[ld_addr] = ld_data;
        end
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_opcode_d = op_q;
        alu_a_d      = rf_q[rs1_q];
        alu_b_d      = unary_op ? '0 : rf_q[rs2_q];
        state_d      = S_CAPTURE;
      end
      S_CAPTURE: begin
        rf_d[rd_q]  = alu_y;
        res_data_d  = alu_y;
        res_rd_d    = rd_q;
        res_valid_d = 1'b1;
        res_zero_d  = (alu_y == '0);
        res_neg_d   = alu_y[DATA_W-1];
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_rd_q     <= '0;
      res_zero_q   <= 1'b0;
      res_neg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rf_q         <= rf_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      res_zero_q   <= res_zero_d;
      res_neg_q    <= res_neg_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;

`ifdef STATUS_FLAGS_EN
  assign res_zero = res_zero_q;
  assign res_neg  = res_neg_q;
`else
  logic unused_flags;
  assign unused_flags = res_zero_q ^ res_neg_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: transaction-level reference model plus directed literal checks
// and a randomized per-cycle stimulus phase. Define STATUS_FLAGS_EN to also check the flag outputs.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [1:0] res_rd;
`ifdef STATUS_FLAGS_EN
  logic       res_zero, res_neg;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  alu_issue_ctrl #(.DATA_W(8), .REG_AW(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd)
`ifdef STATUS_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a + 8'd1;
      3'd3: return a - 8'd1;
      3'd4: return ~a;
      3'd5: return a & b;
      3'd6: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // The external ALU the controller drives
  always_comb alu_y = alu_ref(alu_opcode, alu_a, alu_b);

  // Transaction-level model: operands and result fixed at accept, then revealed on the documented cycles
  logic [7:0] m_rf [4];
  bit         m_idle = 1'b1;
  int         m_age = 0;
  logic [2:0] m_op = '0;
  logic [1:0] m_rd = '0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0] e_op = '0;
  logic [7:0] e_a = '0, e_b = '0, e_data = '0;
  logic [1:0] e_rd = '0;
  bit         e_valid = 1'b0, e_zero = 1'b0, e_neg = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_idle = 1'b1; m_age = 0;
      e_op = '0; e_a = '0; e_b = '0; e_data = '0; e_rd = '0;
      e_valid = 1'b0; e_zero = 1'b0; e_neg = 1'b0;
    end else if (m_idle) begin
      if (ld_en) m_rf[ld_addr] = ld_data;
      if (instr_valid) begin
        m_op  = instr_op;
        m_rd  = instr_rd;
        m_a   = m_rf[instr_rs1];
        m_b   = (instr_op inside {3'd2, 3'd3, 3'd4}) ? 8'h00 : m_rf[instr_rs2];
        m_res = alu_ref(m_op, m_a, m_b);
        m_idle = 1'b0;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        e_op = m_op; e_a = m_a; e_b = m_b;
      end else if (m_age == 2) begin
        m_rf[m_rd] = m_res;
        e_valid = 1'b1; e_data = m_res; e_rd = m_rd;
        e_zero = (m_res == 8'h00); e_neg = m_res[7];
      end else if (res_ready) begin
        e_valid = 1'b0;
        m_idle  = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      checkOutput("instr_ready", instr_ready, m_idle);
      checkOutput("alu_opcode", alu_opcode, e_op);
      checkOutput("alu_a", alu_a, e_a);
      checkOutput("alu_b", alu_b, e_b);
      checkOutput("res_valid", res_valid, e_valid);
      checkOutput("res_data", res_data, e_data);
      checkOutput("res_rd", res_rd, e_rd);
`ifdef STATUS_FLAGS_EN
      checkOutput("res_zero", res_zero, e_zero);
      checkOutput("res_neg", res_neg, e_neg);
`endif
    end
  end

  logic [2:0] cap_op;
  logic [7:0] cap_a, cap_b, cap_res;
  logic [1:0] cap_rd;
  logic       cap_zero, cap_neg;

  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One full transaction from the accept cycle to the result handshake
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                               input logic [1:0] rs2, input bit ld, input logic [1:0] la,
                               input logic [7:0] ldv, input int hold, input bit pulse);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) checkOutput("ready_timeout", instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    ld_en = ld; ld_addr = la; ld_data = ldv; res_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0; ld_en = 1'b0;
    @(negedge clk);
    cap_op = alu_opcode; cap_a = alu_a; cap_b = alu_b;
    @(negedge clk);
    checkOutput("latency_res_valid", res_valid, 1);
    cap_res = res_data; cap_rd = res_rd;
`ifdef STATUS_FLAGS_EN
    cap_zero = res_zero; cap_neg = res_neg;
`else
    cap_zero = 1'b0; cap_neg = 1'b0;
`endif
    for (int i = 0; i < hold; i++) begin
      instr_valid = pulse; instr_op = 3'd7; instr_rd = 2'd0;
      @(negedge clk);
      checkOutput("bp_res_data", res_data, cap_res);
      checkOutput("bp_instr_ready", instr_ready, 0);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("back_to_idle", instr_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_res_data", res_data, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", instr_ready, 1);

    for (int x = 0; x < 4; x++) begin
      applyStimulus(3'd0, x[1:0], x[1:0], 2'd0, 1'b0, 2'd0, 8'h00, 0, 1'b0);
      checkOutput("rf_cleared", cap_res, 8'h00);
    end

    load(2'd1, 8'h0F);
    load(2'd2, 8'h01);
    applyStimulus(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 0, 1'b0);
    checkOutput("add_opcode", cap_op, 3'd0);
    checkOutput("add_a", cap_a, 8'h0F);
    checkOutput("add_b", cap_b, 8'h01);
    checkOutput("add_res", cap_res, 8'h10);
    checkOutput("add_rd", cap_rd, 2'd3);

    load(2'd1, 8'hFF);
    applyStimulus(3'd2, 2'd1, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 0, 1'b0);
    checkOutput("wrap_res", cap_res, 8'h00);
    checkOutput("wrap_b", cap_b, 8'h00);
`ifdef STATUS_FLAGS_EN
    checkOutput("wrap_zero", cap_zero, 1);
    checkOutput("wrap_neg", cap_neg, 0);
`endif
    applyStimulus(3'd0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 8'h00, 0, 1'b0);
    checkOutput("wrap_r1_now_zero", cap_res, 8'h00);

    // r3 holds 0x10 from the add above; and with itself keeps 0x10
    applyStimulus(3'd5, 2'd2, 2'd3, 2'd3, 1'b0, 2'd0, 8'h00, 5, 1'b1);
    checkOutput("bp_res", cap_res, 8'h10);

    applyStimulus(3'd4, 2'd2, 2'd1, 2'd0, 1'b1, 2'd1, 8'h55, 0, 1'b0);
    checkOutput("ldacc_a", cap_a, 8'h55);
    checkOutput("ldacc_res", cap_res, 8'hAA);

    load(2'd3, 8'h22);
    instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_alu_a", alu_a, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", instr_ready, 1);
    applyStimulus(3'd0, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 0, 1'b0);
    checkOutput("abort_r3_cleared", cap_res, 8'h00);

    for (int c = 0; c < 600; c++) begin
      ld_en       = ($urandom_range(0, 2) == 0);
      ld_addr     = 2'($urandom);
      ld_data     = 8'($urandom);
      instr_valid = ($urandom_range(0, 2) == 0);
      instr_op    = 3'($urandom);
      instr_rd    = 2'($urandom);
      instr_rs1   = 2'($urandom);
      instr_rs2   = 2'($urandom);
      res_ready   = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    instr_valid = 1'b0; ld_en = 1'b0; res_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential issue controller that drives the combinational 8-op ALU (opcode/A/B in, Y out) from the initiator side. It accepts encoded instructions over a valid/ready handshake, reads operands from a small internal register file, and presents registered opcode/operands to the ALU. It then captures Y, writes it back to the destination register, and returns the result over a second valid/ready handshake.

Parameters:
DATA_W, 8, operand/result width; equals the ALU package width N.
REG_AW, 2, register-file address width (2**REG_AW registers).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  instruction accepted when valid&ready
instr_op  input  3  ALU opcode: 0 add, 1 sub, 2 inc A, 3 dec A, 4 inv A, 5 and, 6 or, 7 xor
instr_rd  input  REG_AW  destination register
instr_rs1  input  REG_AW  source A register
instr_rs2  input  REG_AW  source B register
ld_en  input  1  register-file load strobe, honoured only in IDLE
ld_addr  input  REG_AW  load address
ld_data  input  DATA_W  load data
alu_opcode  output  3  to ALU opcode
alu_a  output  DATA_W  to ALU A
alu_b  output  DATA_W  to ALU B
alu_y  input  DATA_W  from ALU Y, combinational from alu_* outputs
res_valid  output  1  result available
res_ready  input  1  result consumed when valid&ready
res_data  output  DATA_W  result value
res_rd  output  REG_AW  destination register of result

Behaviour:
- Reset (async, rst=1): state IDLE; all register-file entries 0. alu_opcode, alu_a, alu_b, res_data, res_rd are 0. res_valid is 0. instr_ready is 1 one cycle after rst deasserts (combinational from IDLE).
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch op/rd/rs1/rs2 and go to ISSUE.
  - ISSUE: at clock edge, alu_opcode<=op, alu_a<=rf[rs1], alu_b<=rf[rs2]. For op 2/3/4, alu_b<=0. Go to CAPTURE.
  - CAPTURE: alu outputs stable; at edge, rf[rd]<=alu_y, res_data<=alu_y, res_rd<=rd, res_valid<=1. Go to RESP.
  - RESP: hold res_valid, res_data and res_rd stable. On res_ready, at that edge res_valid<=0 and go to IDLE.
- instr_ready=0 in ISSUE/CAPTURE/RESP; instr_valid is ignored there.
- Latency: accept edge (cycle 0) -> res_valid high in cycle 3. Minimum issue interval is 4 cycles.
- alu_* outputs are registered and hold their last value after the operation.
- Arithmetic is performed by the ALU, modulo 2**DATA_W. The controller does no width extension.
- ld_en in IDLE writes rf[ld_addr] at the edge. ld_en outside IDLE is dropped.
- ld_en together with instruction accept in the same IDLE cycle: the load happens first. The ISSUE read sees the new value.
- rd may equal rs1 and/or rs2; operands are already registered before writeback.
- Reset mid-operation: aborts immediately. No writeback occurs; res_valid=0; register file cleared.

Optional Feature:
STATUS_FLAGS_EN: when defined, adds output ports res_zero (res_data==0) and res_neg (res_data[DATA_W-1]). Both are registered with res_data in CAPTURE and are 0 on reset. When undefined, the ports do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream -> all outputs 0, res_valid=0. After release, instr_ready=1 and every rf entry reads 0 (verify via add rX+r0).
- Add: load r1=0x0F, r2=0x01; issue op0 rd=3 -> in cycle 2 alu_opcode=0, alu_a=0x0F, alu_b=0x01. In cycle 3 res_valid=1, res_data=0x10, res_rd=3.
- Wrap: r1=0xFF, issue inc rd=1 rs1=1 -> res_data=0x00, alu_b=0x00, r1 becomes 0x00. With STATUS_FLAGS_EN, res_zero=1 and res_neg=0.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid/res_data stable and instr_ready=0. An instr_valid pulse is not accepted. Release -> IDLE next cycle.
- Simultaneous load+accept: in IDLE, ld r1=0x55 plus inv rd=2 rs1=1 -> alu_a=0x55, res_data=0xAA.
- Reset in CAPTURE: r3=0x22, issue add rd=3 r1+r2, pulse rst in CAPTURE -> res_valid stays 0, r3 reads 0x00 afterwards.
